rf_operand_fetch: RTL and testbench
===================================

# rf_operand_fetch

Operand-fetch stage that drives the read side of the core's SRAM-based register file and supplies resolved rs1/rs2 values to execute. Accepts decoded instructions on a valid/ready input, issues read addresses to the register file, absorbs the file's one-cycle read latency, and forwards writeback data so operands are never stale. It also passes the writeback port through to the register-file write port, making it the single master of the register-file interface.

## Interface
- XLEN, 32: operand and register data width.
- PAYLOAD_W, 64: width of opaque decoded-instruction payload carried alongside operands.

- clk  in  1  core clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts this cycle.
- in_rs1, in_rs2  in  5 each  source register indices.
- in_payload  in  PAYLOAD_W  opaque; delivered unchanged.
- rf_rd1_addr, rf_rd2_addr  out  5 each  register-file read addresses.
- rf_rd1_data, rf_rd2_data  in  XLEN each  read data, valid the cycle after the address is presented; reflects file contents before any write in the issue cycle.
- rf_wr_en, rf_wr_addr, rf_wr_data  out  1/5/XLEN  register-file write port; combinational copy of wb_*.
- wb_en, wb_addr, wb_data  in  1/5/XLEN  writeback from retire stage.
- out_valid  out  1  operands valid.
- out_ready  in  1  execute accepts.
- out_rs1_val, out_rs2_val  out  XLEN each  resolved operands.
- out_payload  out  PAYLOAD_W  payload of the instruction on the output.

## Operation
- Two stages: S1 (issue, holds rs1/rs2/payload) and S2 (output register, holds operands/payload).
- Accept = in_valid & in_ready. S1 advances when s1_valid & (!s2_valid | out_ready). in_ready = !rst & (!s1_valid | S1 advances).
- Read address mux: on accept, rf_rdN_addr = in_rsN; otherwise rf_rdN_addr = S1's rsN. A stalled S1 re-reads every cycle so returned data tracks intervening writes.
- Issue bypass: in the cycle an address is presented, if wb_en & wb_addr == that address & address != 0, latch wb_data and a hit flag per operand in S1; the hit overrides rf data on the next cycle.
- Arrival bypass: when S1 advances, the operand value written to S2 is chosen in priority order: current-cycle wb match (wb_en, wb_addr == rsN, rsN != 0) -> wb_data; else the latched issue hit -> latched data; else rf_rdN_data.
- x0: any operand with index 0 is forced to 0, never bypassed, regardless of rf data.
- S2 snoop: while s2_valid and not transferring, a wb write matching a nonzero rsN held in S2 replaces that operand, so the held output always equals architectural state.
- Write pass-through: rf_wr_en = wb_en & (wb_addr != 0); rf_wr_addr = wb_addr; rf_wr_data = wb_data.
- Payload is never modified. No flush input; squashing is handled downstream via payload.

## Timing
- Reset: s1_valid = 0, s2_valid = 0, out_valid = 0, out_rs1_val = out_rs2_val = 0, out_payload = 0, latched hit flags = 0, in_ready = 0 while rst is high and 1 in the first cycle after it.
- Reset mid-operation: instructions in S1/S2 are discarded with no output. The write pass-through remains combinational during reset.
- Latency: an instruction accepted in cycle t has out_valid in cycle t+2 when unstalled. Throughput is 1 per cycle.
- Full: both stages valid and out_ready = 0 gives in_ready = 0. out_payload and operands hold stable except for snoop updates.
- Simultaneous out_ready and accept: S2 loads from S1 and S1 loads the new instruction in the same edge; there is no bubble.
- Write in the same cycle as S1 to S2 transfer takes precedence over both rf data and the latched hit.
- When both rs1 == rs2, the two operands are resolved independently but yield identical values.

## Test plan
- Basic: regfile preloaded x5 = 0x11, x6 = 0x22; accept rs1 = 5, rs2 = 6 at t -> at t+2 out_valid = 1, out_rs1_val = 0x11, out_rs2_val = 0x22, payload unchanged.
- Issue-cycle bypass: accept rs1 = 7 at t with wb_en, wb_addr = 7, wb_data = 0xDEAD in the same cycle -> out_rs1_val = 0xDEAD.
- Arrival bypass and S2 snoop: write x8 = 0xBEEF at t+1 -> operand 0xBEEF. With out_ready = 0, write x8 = 0xCAFE at t+4 -> out_rs1_val = 0xCAFE from t+5 while out_valid stays 1.
- x0: rs1 = 0 with wb_en, wb_addr = 0, wb_data = 0xFFFFFFFF -> out_rs1_val = 0 and rf_wr_en = 0.
- Back-pressure: stream 6 instructions with out_ready toggling 1,0,0,1 -> in_ready drops when both stages are full, every instruction appears exactly once in order, and none are lost or duplicated.
- Reset mid-stream: assert rst with S1 and S2 valid -> the next cycle out_valid = 0 and outputs = 0. After release, the first accepted instruction emerges 2 cycles later.

Source files
------------

// File: rtl/rf_operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_operand_fetch_if
//  Description : Bundle of the operand-fetch stage's handshake and bus
//                signals: decoded-instruction input, register-file read and
//                write ports, writeback input and operand output.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_operand_fetch_if #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 64
);
    // Decoded-instruction input
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [PAYLOAD_W-1:0] in_payload;

    // Register-file read port
    logic [4:0]           rf_rd1_addr;
    logic [4:0]           rf_rd2_addr;
    logic [XLEN-1:0]      rf_rd1_data;
    logic [XLEN-1:0]      rf_rd2_data;

    // Register-file write port
    logic                 rf_wr_en;
    logic [4:0]           rf_wr_addr;
    logic [XLEN-1:0]      rf_wr_data;

    // Writeback from retire
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [XLEN-1:0]      wb_data;

    // Resolved operand output
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_rs1_val;
    logic [XLEN-1:0]      out_rs2_val;
    logic [PAYLOAD_W-1:0] out_payload;

    // View of the operand-fetch stage itself
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_payload,
        output in_ready,
        output rf_rd1_addr, rf_rd2_addr,
        input  rf_rd1_data, rf_rd2_data,
        output rf_wr_en, rf_wr_addr, rf_wr_data,
        input  wb_en, wb_addr, wb_data,
        output out_valid, out_rs1_val, out_rs2_val, out_payload,
        input  out_ready
    );

    // View of the surrounding core (decode, register file, retire, execute)
    modport master (
        output in_valid, in_rs1, in_rs2, in_payload,
        input  in_ready,
        input  rf_rd1_addr, rf_rd2_addr,
        output rf_rd1_data, rf_rd2_data,
        input  rf_wr_en, rf_wr_addr, rf_wr_data,
        output wb_en, wb_addr, wb_data,
        input  out_valid, out_rs1_val, out_rs2_val, out_payload,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/rf_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : rf_operand_fetch
//  Description : Two-stage operand fetch. S1 issues register-file reads and
//                absorbs the one-cycle read latency, S2 holds the resolved
//                operands for execute. Writeback is forwarded at issue, at
//                arrival and while S2 is held, so operands are never stale.
//                The writeback port is passed through to the file write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_operand_fetch #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 64
) (
    input  wire logic               clk,
    input  wire logic               rst,
    rf_operand_fetch_if.slave       fetch_if
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 s1_valid_q;
    logic [4:0]           s1_rs1_q;
    logic [4:0]           s1_rs2_q;
    logic [PAYLOAD_W-1:0] s1_payload_q;
    logic                 s1_hit1_q;
    logic                 s1_hit2_q;
    logic [XLEN-1:0]      s1_hdata1_q;
    logic [XLEN-1:0]      s1_hdata2_q;

    logic                 s2_valid_q;
    logic [4:0]           s2_rs1_q;
    logic [4:0]           s2_rs2_q;
    logic [XLEN-1:0]      s2_val1_q;
    logic [XLEN-1:0]      s2_val2_q;
    logic [PAYLOAD_W-1:0] s2_payload_q;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_adv;
    logic accept;
    logic s1_hold;

    assign s1_adv  = s1_valid_q & (~s2_valid_q | fetch_if.out_ready);
    assign fetch_if.in_ready = ~rst & (~s1_valid_q | s1_adv);
    assign accept  = fetch_if.in_valid & fetch_if.in_ready;
    // S1 keeps its instruction and re-reads the file this cycle
    assign s1_hold = s1_valid_q & ~s1_adv;

    // ------------------------------------------------------------------
    // Read addresses: new instruction on accept, otherwise S1 re-reads
    // ------------------------------------------------------------------
    logic [4:0] rd1_addr;
    logic [4:0] rd2_addr;

    assign rd1_addr = accept ? fetch_if.in_rs1 : s1_rs1_q;
    assign rd2_addr = accept ? fetch_if.in_rs2 : s1_rs2_q;
    assign fetch_if.rf_rd1_addr = rd1_addr;
    assign fetch_if.rf_rd2_addr = rd2_addr;

    // Writes landing in the read cycle are invisible to the returned data
    logic iss_hit1;
    logic iss_hit2;

    assign iss_hit1 = fetch_if.wb_en & (fetch_if.wb_addr == rd1_addr) & (rd1_addr != 5'd0);
    assign iss_hit2 = fetch_if.wb_en & (fetch_if.wb_addr == rd2_addr) & (rd2_addr != 5'd0);

    // Writes in the cycle S1 moves to S2 beat both file data and the latch
    logic arr_hit1;
    logic arr_hit2;

    assign arr_hit1 = fetch_if.wb_en & (fetch_if.wb_addr == s1_rs1_q) & (s1_rs1_q != 5'd0);
    assign arr_hit2 = fetch_if.wb_en & (fetch_if.wb_addr == s1_rs2_q) & (s1_rs2_q != 5'd0);

    // Writes to registers already held in S2
    logic snoop1;
    logic snoop2;

    assign snoop1 = fetch_if.wb_en & (fetch_if.wb_addr == s2_rs1_q) & (s2_rs1_q != 5'd0);
    assign snoop2 = fetch_if.wb_en & (fetch_if.wb_addr == s2_rs2_q) & (s2_rs2_q != 5'd0);

    // ------------------------------------------------------------------
    // Operand resolution for the S1 -> S2 transfer
    // ------------------------------------------------------------------
    logic [XLEN-1:0] s2_val1_d;
    logic [XLEN-1:0] s2_val2_d;

    // Priority: x0, current writeback, latched issue hit, file data
    always_comb begin
        s2_val1_d = fetch_if.rf_rd1_data;
        s2_val2_d = fetch_if.rf_rd2_data;
        if (s1_hit1_q) s2_val1_d = s1_hdata1_q;
        if (s1_hit2_q) s2_val2_d = s1_hdata2_q;
        if (arr_hit1)  s2_val1_d = fetch_if.wb_data;
        if (arr_hit2)  s2_val2_d = fetch_if.wb_data;
        if (s1_rs1_q == 5'd0) s2_val1_d = '0;
        if (s1_rs2_q == 5'd0) s2_val2_d = '0;
    end

    // S1: issue stage, captures the instruction and per-read bypass hits
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_rs1_q     <= 5'd0;
            s1_rs2_q     <= 5'd0;
            s1_payload_q <= '0;
            s1_hit1_q    <= 1'b0;
            s1_hit2_q    <= 1'b0;
            s1_hdata1_q  <= '0;
            s1_hdata2_q  <= '0;
        end else begin
            if (accept) begin
                s1_valid_q   <= 1'b1;
                s1_rs1_q     <= fetch_if.in_rs1;
                s1_rs2_q     <= fetch_if.in_rs2;
                s1_payload_q <= fetch_if.in_payload;
            end else if (s1_adv) begin
                s1_valid_q   <= 1'b0;
            end

            // Each read refreshes the hit: the file catches up with older writes
            if (accept || s1_hold) begin
                s1_hit1_q   <= iss_hit1;
                s1_hit2_q   <= iss_hit2;
                s1_hdata1_q <= fetch_if.wb_data;
                s1_hdata2_q <= fetch_if.wb_data;
            end else begin
                s1_hit1_q   <= 1'b0;
                s1_hit2_q   <= 1'b0;
            end
        end
    end

    // S2: output register, loads from S1 or snoops writeback while held
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_rs1_q     <= 5'd0;
            s2_rs2_q     <= 5'd0;
            s2_val1_q    <= '0;
            s2_val2_q    <= '0;
            s2_payload_q <= '0;
        end else if (s1_adv) begin
            s2_valid_q   <= 1'b1;
            s2_rs1_q     <= s1_rs1_q;
            s2_rs2_q     <= s1_rs2_q;
            s2_val1_q    <= s2_val1_d;
            s2_val2_q    <= s2_val2_d;
            s2_payload_q <= s1_payload_q;
        end else if (s2_valid_q && fetch_if.out_ready) begin
            s2_valid_q   <= 1'b0;
        end else if (s2_valid_q) begin
            if (snoop1) s2_val1_q <= fetch_if.wb_data;
            if (snoop2) s2_val2_q <= fetch_if.wb_data;
        end
    end

    assign fetch_if.out_valid   = s2_valid_q;
    assign fetch_if.out_rs1_val = s2_val1_q;
    assign fetch_if.out_rs2_val = s2_val2_q;
    assign fetch_if.out_payload = s2_payload_q;

    // ------------------------------------------------------------------
    // Write pass-through; x0 is never written
    // ------------------------------------------------------------------
    assign fetch_if.rf_wr_en   = fetch_if.wb_en & (fetch_if.wb_addr != 5'd0);
    assign fetch_if.rf_wr_addr = fetch_if.wb_addr;
    assign fetch_if.rf_wr_data = fetch_if.wb_data;

endmodule
`default_nettype wire

// File: tb/tb_rf_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_operand_fetch
//  Description : Bench for rf_operand_fetch: SRAM register-file model,
//                architectural reference model with in-order scoreboard,
//                directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_operand_fetch;
    localparam int XLEN = 32;
    localparam int PW   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_operand_fetch_if #(.XLEN(XLEN), .PAYLOAD_W(PW)) bus ();

    rf_operand_fetch #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_if (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Register file: one-cycle read latency, read-before-write
    // ------------------------------------------------------------------
    logic [XLEN-1:0] init_val [32];
    logic [XLEN-1:0] mem      [32];
    logic            mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem        <= init_val;
            mem_loaded <= 1'b1;
        end else begin
            if (bus.rf_wr_en) mem[bus.rf_wr_addr] <= bus.rf_wr_data;
        end
        bus.rf_rd1_data <= mem[bus.rf_rd1_addr];
        bus.rf_rd2_data <= mem[bus.rf_rd2_addr];
    end

    // ------------------------------------------------------------------
    // Reference model: architectural registers plus in-order queue
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [PW-1:0] pl;
        int            acc;
    } ins_t;

    ins_t            q[$];
    logic [XLEN-1:0] arch [32];
    bit              arch_loaded = 1'b0;

    always @(negedge clk) begin : b_cmp
        bit   exp_ready;
        bit   exp_valid;
        ins_t ni;
        if (!arch_loaded) begin
            arch        = init_val;
            arch_loaded = 1'b1;
        end
        cyc++;
        chk("rf_wr_en", bus.rf_wr_en, bus.wb_en && (bus.wb_addr != 5'd0));
        if (bus.wb_en) begin
            chk("rf_wr_addr", bus.rf_wr_addr, bus.wb_addr);
            chk("rf_wr_data", bus.rf_wr_data, bus.wb_data);
        end
        if (rst) begin
            chk("in_ready_in_reset", bus.in_ready, 0);
        end else begin
            exp_ready = !(q.size() == 2 && !bus.out_ready);
            exp_valid = (q.size() > 0) && (q[0].acc + 2 <= cyc);
            chk("in_ready", bus.in_ready, exp_ready);
            chk("out_valid", bus.out_valid, exp_valid);
            if (exp_valid && bus.out_valid) begin
                chk("out_payload", bus.out_payload, q[0].pl);
                chk("out_rs1_val", bus.out_rs1_val, (q[0].rs1 == 5'd0) ? 32'h0 : arch[q[0].rs1]);
                chk("out_rs2_val", bus.out_rs2_val, (q[0].rs2 == 5'd0) ? 32'h0 : arch[q[0].rs2]);
            end
            if (exp_valid && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && exp_ready) begin
                ni.rs1 = bus.in_rs1;
                ni.rs2 = bus.in_rs2;
                ni.pl  = bus.in_payload;
                ni.acc = cyc;
                q.push_back(ni);
            end
        end
        if (bus.wb_en && bus.wb_addr != 5'd0) arch[bus.wb_addr] = bus.wb_data;
        if (rst) q.delete();
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_rs1     = 5'd0;
        bus.in_rs2     = 5'd0;
        bus.in_payload = '0;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = 5'd0;
        bus.wb_data    = '0;
        bus.out_ready  = 1'b1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [63:0] pl);
        bus.in_valid   = 1'b1;
        bus.in_rs1     = r1;
        bus.in_rs2     = r2;
        bus.in_payload = pl;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] got[$];
        int          k;
        bit          saw_drop;

        for (int i = 0; i < 32; i++) init_val[i] = $urandom;
        init_val[0] = 32'hBAD0_BAD0;
        init_val[5] = 32'h11;
        init_val[6] = 32'h22;
        idle();
        rst = 1'b1;
        repeat (3) next();
        rst = 1'b0;
        next();

        // Basic read with two-cycle latency
        issue(5, 6, 64'hA5A5_0001);
        @(negedge clk) chk("basic_in_ready", bus.in_ready, 1);
        next(); idle();
        @(negedge clk) chk("basic_not_yet", bus.out_valid, 0);
        next();
        @(negedge clk);
        chk("basic_valid", bus.out_valid, 1);
        chk("basic_rs1", bus.out_rs1_val, 32'h11);
        chk("basic_rs2", bus.out_rs2_val, 32'h22);
        chk("basic_payload", bus.out_payload, 64'hA5A5_0001);

        // Write in the issue cycle
        next(); idle();
        issue(7, 0, 64'h2);
        wb(7, 32'hDEAD);
        next(); idle();
        next();
        @(negedge clk);
        chk("issue_byp_rs1", bus.out_rs1_val, 32'hDEAD);
        chk("issue_byp_rs2", bus.out_rs2_val, 32'h0);

        // Write in the arrival cycle, then snoop while held
        next(); idle();
        issue(8, 8, 64'h3);
        next(); idle();
        wb(8, 32'hBEEF);
        next(); idle();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("arrive_valid", bus.out_valid, 1);
        chk("arrive_rs1", bus.out_rs1_val, 32'hBEEF);
        chk("arrive_rs2", bus.out_rs2_val, 32'hBEEF);
        next(); idle();
        bus.out_ready = 1'b0;
        next(); idle();
        bus.out_ready = 1'b0;
        wb(8, 32'hCAFE);
        @(negedge clk) chk("snoop_before", bus.out_rs1_val, 32'hBEEF);
        next(); idle();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("snoop_valid", bus.out_valid, 1);
        chk("snoop_rs1", bus.out_rs1_val, 32'hCAFE);
        chk("snoop_rs2", bus.out_rs2_val, 32'hCAFE);
        next(); idle();

        // x0 is never bypassed or written
        next(); idle();
        issue(0, 5, 64'h4);
        wb(0, 32'hFFFF_FFFF);
        @(negedge clk) chk("x0_wr_en", bus.rf_wr_en, 0);
        next(); idle();
        next();
        @(negedge clk);
        chk("x0_rs1", bus.out_rs1_val, 32'h0);
        chk("x0_rs2", bus.out_rs2_val, 32'h11);

        // Back-pressure stream of six instructions
        next(); idle();
        k = 0;
        saw_drop = 1'b0;
        for (int c = 0; c < 60 && got.size() < 6; c++) begin
            next(); idle();
            bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
            if (k < 6) issue(5'(k + 1), 5'(k + 2), 64'hB000 + 64'(k));
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_payload);
            if (bus.in_valid && !bus.in_ready) saw_drop = 1'b1;
            if (bus.in_valid && bus.in_ready) k++;
        end
        chk("bp_in_ready_drop", saw_drop, 1);
        chk("bp_count", got.size(), 6);
        for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], 64'hB000 + 64'(i));
        next(); idle();
        next(); idle();

        // Reset with both stages full
        issue(5, 6, 64'hC1);
        bus.out_ready = 1'b0;
        next(); idle();
        issue(6, 5, 64'hC2);
        bus.out_ready = 1'b0;
        next(); idle();
        bus.out_ready = 1'b0;
        @(negedge clk) chk("rst_full", bus.out_valid, 1);
        next(); idle();
        rst = 1'b1;
        @(negedge clk) chk("rst_in_ready", bus.in_ready, 0);
        next(); idle();
        rst = 1'b0;
        issue(5, 6, 64'hC3);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_rs1", bus.out_rs1_val, 0);
        chk("rst_rs2", bus.out_rs2_val, 0);
        chk("rst_payload", bus.out_payload, 0);
        chk("rst_ready_after", bus.in_ready, 1);
        next(); idle();
        next();
        @(negedge clk);
        chk("rst_first_valid", bus.out_valid, 1);
        chk("rst_first_payload", bus.out_payload, 64'hC3);
        chk("rst_first_rs1", bus.out_rs1_val, 32'h11);

        // Randomized traffic with hazards concentrated on x0..x7
        for (int c = 0; c < 3000; c++) begin
            next();
            rst            = ($urandom % 250 == 0);
            bus.in_valid   = ($urandom % 4 != 0);
            bus.in_rs1     = 5'($urandom_range(0, 7));
            bus.in_rs2     = 5'($urandom_range(0, 7));
            bus.in_payload = {$urandom, $urandom};
            bus.wb_en      = ($urandom % 2 == 0);
            bus.wb_addr    = 5'($urandom_range(0, 7));
            bus.wb_data    = $urandom;
            bus.out_ready  = ($urandom % 3 != 0);
        end
        next(); rst = 1'b0; idle();
        repeat (5) next();
        @(negedge clk) chk("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
